// File: rtl/regbank_pkg.sv
// Shared constants for the DCPU byte-register bank: pair-op codes, pair map, reset values.
// Latency: none (package of constants only).
// Backpressure: none.
package regbank_pkg;

  // Pair operation encoding carried on i_pair_op
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  // Default pair map of the 12-byte bank
  localparam int PAIR_AB = 0;
  localparam int PAIR_CD = 1;
  localparam int PAIR_EF = 2;
  localparam int PAIR_GH = 3;
  localparam int PAIR_SP = 4;
  localparam int PAIR_PC = 5;

  // Default post-reset values of the stack pointer and program counter
  localparam logic [15:0] RESET_SP_DEF = 16'hFFFF;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage : regbank_pkg

// File: rtl/regbank_pair_incdec.sv
// Combinational +1/-1 unit for one register pair, with a zero detect on the result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is always valid for the current input.
module pair_incdec
  import regbank_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic [W-1:0] o_val,
  output logic         o_zero
);

  // Step by one in either direction; natural modular wrap gives FFFF+1=0 and 0-1=FFFF
  always_comb begin
    o_val  = i_dec ? (i_val - W'(1)) : (i_val + W'(1));
    o_zero = (o_val == '0);
  end

endmodule : pair_incdec

// File: rtl/regbank.sv
// Byte-register bank organised as pairs, with pair load/inc/dec, autonomous PC increment and zero flag.
// Latency: reads combinational from current state; all writes visible after the next rising edge.
// Backpressure: none; every operation presented is accepted on the edge (invalid selects are dropped).
module regbank
  import regbank_pkg::*;
#(
  parameter int              DW       = 8,
  parameter int              NREGS    = 12,
  parameter int              SELW     = 4,
  parameter int              PSELW    = 3,
  parameter int              SP_PAIR  = PAIR_SP,
  parameter int              PC_PAIR  = PAIR_PC,
  parameter logic [2*DW-1:0] RESET_SP = RESET_SP_DEF,
  parameter logic [2*DW-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DW-1:0]     i_dat,
  input  logic              i_load,
  input  logic [SELW-1:0]   i_load_reg_sel,
  input  logic [SELW-1:0]   i_alu_l_sel,
  input  logic [SELW-1:0]   i_alu_r_sel,
  output logic [DW-1:0]     o_alu_l,
  output logic [DW-1:0]     o_alu_r,
  input  logic [PSELW-1:0]  i_addr_sel,
  output logic [2*DW-1:0]   o_addr,
  input  logic [PSELW-1:0]  i_pair_sel,
  input  logic [1:0]        i_pair_op,
  input  logic [2*DW-1:0]   i_pair_dat,
  input  logic              i_pc_inc,
  output logic              o_pair_zero,
  output logic [2*DW-1:0]   o_pc
);

  localparam int NPAIRS = NREGS / 2;
  localparam int AW     = 2 * DW;

  // Architectural state
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic          zero_q;
  logic          zero_d;

  // Pair-op datapath
  logic [AW-1:0] pair_cur;
  logic          pair_hit;
  logic          pair_is_pc;
  logic          pair_act;
  logic          pair_arith;
  logic [AW-1:0] pair_step;
  logic          pair_step_zero;
  logic [AW-1:0] pair_res;

  // PC increment datapath
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] pc_step;
  logic          pc_zero_unused;
  logic          pc_inc_take;

  // Reset value of one byte: SP and PC bytes come from their parameters, all else clears
  function automatic logic [DW-1:0] reset_byte(input int idx);
    logic [DW-1:0] b;
    b = '0;
    if (idx == 2 * SP_PAIR)     b = RESET_SP[DW-1:0];
    if (idx == 2 * SP_PAIR + 1) b = RESET_SP[AW-1:DW];
    if (idx == 2 * PC_PAIR)     b = RESET_PC[DW-1:0];
    if (idx == 2 * PC_PAIR + 1) b = RESET_PC[AW-1:DW];
    return b;
  endfunction

  // Fetch the pair targeted by the pair op; an out-of-range select leaves pair_hit low
  always_comb begin
    pair_cur = '0;
    pair_hit = 1'b0;
    for (int p = 0; p < NPAIRS; p++) begin
      if (i_pair_sel == PSELW'(p)) begin
        pair_cur = {regs_q[2*p+1], regs_q[2*p]};
        pair_hit = 1'b1;
      end
    end
  end

  // Decode which pair operation actually happens this cycle
  always_comb begin
    pair_act    = pair_hit && (i_pair_op != OP_NOP);
    pair_arith  = pair_hit && ((i_pair_op == OP_INC) || (i_pair_op == OP_DEC));
    pair_is_pc  = (i_pair_sel == PSELW'(PC_PAIR));
    pair_res    = (i_pair_op == OP_LOAD) ? i_pair_dat : pair_step;
    // A pair op on PC supersedes the autonomous increment
    pc_inc_take = i_pc_inc && !(pair_act && pair_is_pc);
  end

  assign pc_cur = {regs_q[2*PC_PAIR+1], regs_q[2*PC_PAIR]};

  pair_incdec #(.W(AW)) u_pair_step (
    .i_val  (pair_cur),
    .i_dec  (i_pair_op == OP_DEC),
    .o_val  (pair_step),
    .o_zero (pair_step_zero)
  );

  pair_incdec #(.W(AW)) u_pc_step (
    .i_val  (pc_cur),
    .i_dec  (1'b0),
    .o_val  (pc_step),
    .o_zero (pc_zero_unused)
  );

  // Next state, layered lowest priority first: pc_inc, then pair op, then byte write
  always_comb begin
    regs_d = regs_q;
    if (pc_inc_take) begin
      regs_d[2*PC_PAIR]   = pc_step[DW-1:0];
      regs_d[2*PC_PAIR+1] = pc_step[AW-1:DW];
    end
    for (int p = 0; p < NPAIRS; p++) begin
      if (pair_act && (i_pair_sel == PSELW'(p))) begin
        regs_d[2*p]   = pair_res[DW-1:0];
        regs_d[2*p+1] = pair_res[AW-1:DW];
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      if (i_load && (i_load_reg_sel == SELW'(r))) begin
        regs_d[r] = i_dat;
      end
    end
  end

  // Zero flag follows the raw INC/DEC result, ignoring any byte-write override
  always_comb begin
    zero_d = pair_arith ? pair_step_zero : zero_q;
  end

  // State register with asynchronous reset to the architectural reset values
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= reset_byte(r);
      end
      zero_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      zero_q <= zero_d;
    end
  end

  // ALU operand muxes; select values beyond the bank bypass the data bus
  always_comb begin
    o_alu_l = i_dat;
    o_alu_r = i_dat;
    for (int r = 0; r < NREGS; r++) begin
      if (i_alu_l_sel == SELW'(r)) o_alu_l = regs_q[r];
      if (i_alu_r_sel == SELW'(r)) o_alu_r = regs_q[r];
    end
  end

  // Address bus pair mux; an out-of-range pair drives zero
  always_comb begin
    o_addr = '0;
    for (int p = 0; p < NPAIRS; p++) begin
      if (i_addr_sel == PSELW'(p)) o_addr = {regs_q[2*p+1], regs_q[2*p]};
    end
  end

  assign o_pc        = pc_cur;
  assign o_pair_zero = zero_q;

endmodule : regbank

// File: tb/tb_regbank.sv
// Directed bench for regbank with a queue scoreboard of expected values.
// Latency: inputs driven after the falling edge, outputs sampled before the next rising edge.
// Backpressure: not applicable.
module tb_regbank;
  import regbank_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_dat;
  logic        i_load;
  logic [3:0]  i_load_reg_sel;
  logic [3:0]  i_alu_l_sel;
  logic [3:0]  i_alu_r_sel;
  logic [7:0]  o_alu_l;
  logic [7:0]  o_alu_r;
  logic [2:0]  i_addr_sel;
  logic [15:0] o_addr;
  logic [2:0]  i_pair_sel;
  logic [1:0]  i_pair_op;
  logic [15:0] i_pair_dat;
  logic        i_pc_inc;
  logic        o_pair_zero;
  logic [15:0] o_pc;

  always #5 i_clk = ~i_clk;

  regbank dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_dat          (i_dat),
    .i_load         (i_load),
    .i_load_reg_sel (i_load_reg_sel),
    .i_alu_l_sel    (i_alu_l_sel),
    .i_alu_r_sel    (i_alu_r_sel),
    .o_alu_l        (o_alu_l),
    .o_alu_r        (o_alu_r),
    .i_addr_sel     (i_addr_sel),
    .o_addr         (o_addr),
    .i_pair_sel     (i_pair_sel),
    .i_pair_op      (i_pair_op),
    .i_pair_dat     (i_pair_dat),
    .i_pc_inc       (i_pc_inc),
    .o_pair_zero    (o_pair_zero),
    .o_pc           (o_pc)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_bytes [12];

  task automatic expect_v(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pair_op(input logic [2:0] sel, input logic [1:0] op, input logic [15:0] dat);
    i_pair_sel = sel;
    i_pair_op  = op;
    i_pair_dat = dat;
  endtask

  initial begin
    i_reset = 1'b0; i_dat = 8'h00; i_load = 1'b0; i_load_reg_sel = 4'd0;
    i_alu_l_sel = 4'd0; i_alu_r_sel = 4'd0; i_addr_sel = 3'd0;
    pair_op(3'd0, OP_NOP, 16'h0000); i_pc_inc = 1'b0;

    // Reset with no clock edge seen yet
    #1 i_reset = 1'b1;
    #1;
    expect_v("rst_pc", 16'h0000);   check(o_pc);
    i_addr_sel = 3'd4; #1;
    expect_v("rst_sp", 16'hFFFF);   check(o_addr);
    expect_v("rst_zero", 16'h0000); check({15'd0, o_pair_zero});
    for (int r = 0; r < 12; r++) begin
      i_alu_l_sel = 4'(r); #1;
      expect_v($sformatf("rst_byte%0d", r), (r == 8 || r == 9) ? 16'h00FF : 16'h0000);
      check({8'd0, o_alu_l});
    end
    @(negedge i_clk) i_reset = 1'b0;

    // Byte write, visible only after the edge; r_sel 15 bypasses i_dat
    i_load = 1'b1; i_load_reg_sel = 4'd3; i_dat = 8'hA5; i_alu_l_sel = 4'd3; i_alu_r_sel = 4'd15;
    #1 expect_v("wr_before_edge", 16'h0000); check({8'd0, o_alu_l});
    @(negedge i_clk) i_load = 1'b0; i_dat = 8'h3C;
    #1 expect_v("wr_after_edge", 16'h00A5); check({8'd0, o_alu_l});
    expect_v("bypass_r", 16'h003C); check({8'd0, o_alu_r});

    // Carry across bytes and wrap
    @(negedge i_clk) pair_op(3'd1, OP_LOAD, 16'h12FF);
    @(negedge i_clk) pair_op(3'd1, OP_INC, 16'h0000);
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000); i_addr_sel = 3'd1;
    #1 expect_v("inc_carry", 16'h1300); check(o_addr);
    expect_v("inc_carry_zero", 16'h0000); check({15'd0, o_pair_zero});
    @(negedge i_clk) pair_op(3'd1, OP_LOAD, 16'hFFFF);
    @(negedge i_clk) pair_op(3'd1, OP_INC, 16'h0000);
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000);
    #1 expect_v("inc_wrap", 16'h0000); check(o_addr);
    expect_v("inc_wrap_zero", 16'h0001); check({15'd0, o_pair_zero});
    @(negedge i_clk) pair_op(3'd1, OP_LOAD, 16'h0000);
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000);
    #1 expect_v("zero_hold_load", 16'h0001); check({15'd0, o_pair_zero});
    @(negedge i_clk) pair_op(3'd1, OP_DEC, 16'h0000);
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000);
    #1 expect_v("dec_wrap", 16'hFFFF); check(o_addr);
    expect_v("dec_wrap_zero", 16'h0000); check({15'd0, o_pair_zero});

    // PC increment with carry, then collision with a PC load
    @(negedge i_clk) pair_op(3'd5, OP_LOAD, 16'h00FF);
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000); i_pc_inc = 1'b1;
    @(negedge i_clk) i_pc_inc = 1'b0;
    #1 expect_v("pc_inc_carry", 16'h0100); check(o_pc);
    @(negedge i_clk) pair_op(3'd5, OP_LOAD, 16'h8000); i_pc_inc = 1'b1;
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000); i_pc_inc = 1'b0;
    #1 expect_v("pc_load_wins", 16'h8000); check(o_pc);
    @(negedge i_clk) i_pc_inc = 1'b1;
    @(negedge i_clk) i_pc_inc = 1'b0;
    #1 expect_v("pc_inc_plain", 16'h8001); check(o_pc);

    // Byte write beats pair op on the same byte; flag uses the unmodified result
    @(negedge i_clk) pair_op(3'd0, OP_LOAD, 16'h12FF);
    @(negedge i_clk) pair_op(3'd0, OP_INC, 16'h0000);
    i_load = 1'b1; i_load_reg_sel = 4'd1; i_dat = 8'h55;
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000); i_load = 1'b0; i_addr_sel = 3'd0;
    #1 expect_v("byte_over_pair", 16'h5500); check(o_addr);
    expect_v("byte_over_pair_zero", 16'h0000); check({15'd0, o_pair_zero});
    @(negedge i_clk) pair_op(3'd0, OP_LOAD, 16'hFFFF);
    @(negedge i_clk) pair_op(3'd0, OP_INC, 16'h0000);
    i_load = 1'b1; i_load_reg_sel = 4'd1; i_dat = 8'h55;
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000); i_load = 1'b0;
    #1 expect_v("byte_over_wrap", 16'h5500); check(o_addr);
    expect_v("byte_over_wrap_zero", 16'h0001); check({15'd0, o_pair_zero});

    // Invalid selects change nothing
    @(negedge i_clk) pair_op(3'd7, OP_INC, 16'h0000);
    @(negedge i_clk) pair_op(3'd6, OP_DEC, 16'h0000);
    @(negedge i_clk) pair_op(3'd0, OP_NOP, 16'h0000);
    i_load = 1'b1; i_load_reg_sel = 4'd13; i_dat = 8'h77;
    @(negedge i_clk) i_load_reg_sel = 4'd12;
    @(negedge i_clk) i_load = 1'b0;
    #1 expect_v("inv_zero_hold", 16'h0001); check({15'd0, o_pair_zero});
    i_addr_sel = 3'd6; #1 expect_v("addr_sel6", 16'h0000); check(o_addr);
    i_addr_sel = 3'd7; #1 expect_v("addr_sel7", 16'h0000); check(o_addr);
    i_alu_l_sel = 4'd13; #1 expect_v("bypass_l13", 16'h0077); check({8'd0, o_alu_l});
    exp_bytes = '{8'h00, 8'h55, 8'hFF, 8'hFF, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80};
    for (int r = 0; r < 12; r++) begin
      i_alu_l_sel = 4'(r); #1;
      expect_v($sformatf("inv_byte%0d", r), {8'd0, exp_bytes[r]});
      check({8'd0, o_alu_l});
    end

    // Reset asserted between edges during INC traffic
    @(negedge i_clk) pair_op(3'd2, OP_INC, 16'h0000); i_pc_inc = 1'b1; i_addr_sel = 3'd2;
    @(negedge i_clk);
    @(negedge i_clk);
    #1 expect_v("traffic_ef", 16'h0002); check(o_addr);
    expect_v("traffic_pc", 16'h8003); check(o_pc);
    #1 i_reset = 1'b1;
    #1 expect_v("midrst_pc", 16'h0000); check(o_pc);
    expect_v("midrst_ef", 16'h0000); check(o_addr);
    expect_v("midrst_zero", 16'h0000); check({15'd0, o_pair_zero});
    @(negedge i_clk);
    @(negedge i_clk);
    #1 expect_v("held_pc", 16'h0000); check(o_pc);
    expect_v("held_ef", 16'h0000); check(o_addr);
    i_addr_sel = 3'd4; #1 expect_v("held_sp", 16'hFFFF); check(o_addr);
    i_addr_sel = 3'd2; i_reset = 1'b0;
    @(negedge i_clk);
    #1 expect_v("post_rst_ef", 16'h0001); check(o_addr);
    expect_v("post_rst_pc", 16'h0001); check(o_pc);
    pair_op(3'd0, OP_NOP, 16'h0000); i_pc_inc = 1'b0;

    if (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regbank
